// File: rtl/regwrite_trace_unit_pkg.sv
// Shared record layout for the register-write trace: field widths, bit offsets and
// request decoding used by both the emitter and the host-side trace decode.
package regwrite_trace_unit_pkg;

  localparam int TRACE_ADDR_W   = 4;
  localparam int TRACE_DATA_W   = 32;
  localparam int TRACE_DATA_LSB = 0;
  localparam int TRACE_ADDR_LSB = TRACE_DATA_LSB + TRACE_DATA_W;
  localparam int TRACE_SEQ_LSB  = TRACE_ADDR_LSB + TRACE_ADDR_W;

  // Record is {seq, addr, data}; seq width is a parameter of the emitter.
  function automatic int trace_rec_w(input int seq_w);
    return seq_w + TRACE_ADDR_W + TRACE_DATA_W;
  endfunction

  // Encoding matches {r2, r1} so a plain cast decodes the capture request.
  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_P1   = 2'b01,
    REQ_P2   = 2'b10,
    REQ_BOTH = 2'b11
  } req_e;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Register FIFO with show-ahead head, up to two in-order pushes and one pop per cycle.
// Pushes must be compacted by the caller: push1 is only honoured together with push0.
module trace_fifo_2w1r #(
  parameter int DEPTH = 8,
  parameter int W     = 44,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push0,
  input  logic [W-1:0]  push0_data,
  input  logic          push1,
  input  logic [W-1:0]  push1_data,
  input  logic          pop,
  output logic          head_valid,
  output logic [W-1:0]  head_data,
  output logic [LW-1:0] level,
  output logic [LW-1:0] free
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [PW-1:0] wr_ptr_p1;
  logic          pop_eff;
  logic [1:0]    push_n;

  assign wr_ptr_p1  = wr_ptr_reg + PW'(1);
  assign head_valid = (level_reg != '0);
  assign pop_eff    = pop & head_valid;
  assign push_n     = {1'b0, push0} + {1'b0, push0 & push1};
  assign head_data  = mem[rd_ptr_reg];
  assign level      = level_reg;
  // Space freed by this cycle's pop is usable by this cycle's pushes.
  assign free       = LW'(DEPTH) - level_reg + LW'(pop_eff);

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr_reg] <= push0_data;
    if (push0 && push1) mem[wr_ptr_p1] <= push1_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push_n);
      rd_ptr_reg <= rd_ptr_reg + PW'(pop_eff);
      level_reg  <= level_reg + LW'(push_n) - LW'(pop_eff);
    end
  end

endmodule

// File: rtl/regwrite_trace_unit.sv
// Architectural register-write trace emitter: tags regfile writes with a sequence number,
// queues them for the host trace reader and accounts for records lost to a full queue.
module regwrite_trace_unit
  import regwrite_trace_unit_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 8,
  parameter int DROP_W = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  trace_en,
  input  logic                                  clr_status,
  input  logic                                  we1,
  input  logic [3:0]                            wa1,
  input  logic [31:0]                           wd1,
  input  logic                                  we2,
  input  logic [3:0]                            wa2,
  input  logic [31:0]                           wd2,
  output logic                                  trace_valid,
  input  logic                                  trace_ready,
  output logic [SEQ_W+TRACE_ADDR_W+TRACE_DATA_W-1:0] trace_data,
  output logic                                  ovf_sticky,
  output logic [DROP_W-1:0]                     drop_cnt,
  output logic [$clog2(DEPTH):0]                fifo_level
);

  localparam int REC_W = trace_rec_w(SEQ_W);
  localparam int LW    = $clog2(DEPTH) + 1;

  logic [SEQ_W-1:0]  seq_reg, seq_next;
  logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic              ovf_reg, ovf_next;

  req_e              req;
  logic [1:0]        n_req, n_acc, n_drop;
  logic [REC_W-1:0]  slot0_rec, slot1_rec;
  logic              pop;
  logic [REC_W-1:0]  head_data;
  logic [LW-1:0]     level, free;
  logic [DROP_W-1:0] drop_base;
  logic [DROP_W:0]   drop_sum;

  assign req = req_e'({trace_en & we2, trace_en & we1});
  assign pop = trace_valid & trace_ready;

  always_comb begin
    n_req     = 2'd0;
    slot0_rec = '0;
    slot1_rec = '0;
    case (req)
      REQ_P1: begin
        n_req     = 2'd1;
        slot0_rec = {seq_reg, wa1, wd1};
      end
      REQ_P2: begin
        n_req     = 2'd1;
        slot0_rec = {seq_reg, wa2, wd2};
      end
      REQ_BOTH: begin
        n_req     = 2'd2;
        slot0_rec = {seq_reg, wa1, wd1};
        slot1_rec = {seq_reg + SEQ_W'(1), wa2, wd2};
      end
      default: ;
    endcase

    // Accept in port order until space runs out; the remainder is dropped.
    n_acc = n_req;
    if (LW'(n_req) > free) n_acc = free[1:0];
    n_drop = n_req - n_acc;

    seq_next = seq_reg + SEQ_W'(n_acc);

    // Clear takes effect first so drops in the same cycle are still recorded.
    drop_base     = clr_status ? '0 : drop_cnt_reg;
    drop_sum      = {1'b0, drop_base} + (DROP_W+1)'(n_drop);
    drop_cnt_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    ovf_next      = (ovf_reg & ~clr_status) | (n_drop != 2'd0);
  end

  trace_fifo_2w1r #(
    .DEPTH (DEPTH),
    .W     (REC_W),
    .LW    (LW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push0      (n_acc != 2'd0),
    .push0_data (slot0_rec),
    .push1      (n_acc == 2'd2),
    .push1_data (slot1_rec),
    .pop        (trace_ready),
    .head_valid (trace_valid),
    .head_data  (head_data),
    .level      (level),
    .free       (free)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_reg      <= '0;
      drop_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      seq_reg      <= seq_next;
      drop_cnt_reg <= drop_cnt_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign trace_data = trace_valid ? head_data : '0;
  assign fifo_level = level;
  assign drop_cnt   = drop_cnt_reg;
  assign ovf_sticky = ovf_reg;

endmodule

// File: tb/tb_regwrite_trace_unit.sv
// Directed bench for regwrite_trace_unit: a vector table for single-cycle behaviour plus
// hand-written sequences for backpressure, overflow, wrap and reset mid-drain.
module tb_regwrite_trace_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en, clr_status;
  logic        we1, we2;
  logic [3:0]  wa1, wa2;
  logic [31:0] wd1, wd2;
  logic        trace_valid, trace_ready;
  logic [43:0] trace_data;
  logic        ovf_sticky;
  logic [7:0]  drop_cnt;
  logic [3:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regwrite_trace_unit #(.DEPTH(8), .SEQ_W(8), .DROP_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .trace_en    (trace_en),
    .clr_status  (clr_status),
    .we1         (we1),
    .wa1         (wa1),
    .wd1         (wd1),
    .we2         (we2),
    .wa2         (wa2),
    .wd2         (wd2),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_data  (trace_data),
    .ovf_sticky  (ovf_sticky),
    .drop_cnt    (drop_cnt),
    .fifo_level  (fifo_level)
  );

  typedef struct {
    logic        en, we1;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        we2;
    logic [3:0]  wa2;
    logic [31:0] wd2;
    logic        rdy, clr;
    logic        exp_valid;
    logic [43:0] exp_data;
    int          exp_level;
    int          exp_drop;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [43:0] rec(input int s, input int a, input logic [31:0] d);
    logic [7:0] s8;
    logic [3:0] a4;
    s8 = 8'(s);
    a4 = 4'(a);
    return {s8, a4, d};
  endfunction

  function automatic vec_t mkv(input logic en, input logic w1, input int a1, input logic [31:0] d1,
                               input logic w2, input int a2, input logic [31:0] d2,
                               input logic rdy, input logic clr, input logic ev,
                               input logic [43:0] ed, input int el, input int edr, input logic eo);
    vec_t v;
    v.en = en; v.we1 = w1; v.wa1 = 4'(a1); v.wd1 = d1;
    v.we2 = w2; v.wa2 = 4'(a2); v.wd2 = d2;
    v.rdy = rdy; v.clr = clr;
    v.exp_valid = ev; v.exp_data = ed; v.exp_level = el; v.exp_drop = edr; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic w1, input int a1, input logic [31:0] d1,
                       input logic w2, input int a2, input logic [31:0] d2,
                       input logic rdy, input logic clr);
    trace_en = en; we1 = w1; wa1 = 4'(a1); wd1 = d1;
    we2 = w2; wa2 = 4'(a2); wd2 = d2;
    trace_ready = rdy; clr_status = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b1, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    idle(1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [43:0] e;
    reset = 1'b0;
    drive(1'b1, 1'b1, 0, 32'd10, 1'b0, 0, 32'd0, 1'b0, 1'b0);

    // Reset held with a write pending: nothing is captured.
    repeat (2) step();
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_data",  64'(trace_data),  64'd0);
    chk("rst_level", 64'(fifo_level),  64'd0);
    chk("rst_drop",  64'(drop_cnt),    64'd0);
    chk("rst_ovf",   64'(ovf_sticky),  64'd0);
    reset = 1'b1;
    step();
    $display("reset release: valid=%0d data=0x%0h", trace_valid, trace_data);
    chk("first_valid", 64'(trace_valid), 64'd1);
    chk("first_data",  64'(trace_data),  64'(rec(0, 0, 32'd10)));
    chk("first_level", 64'(fifo_level),  64'd1);

    do_reset();
    tbl[0] = mkv(1, 1, 2, 32'd5, 1, 3, 32'd7, 1, 0,   1, rec(0, 2, 32'd5), 2, 0, 0);
    tbl[1] = mkv(1, 0, 0, 32'd0, 0, 0, 32'd0, 1, 0,   1, rec(1, 3, 32'd7), 1, 0, 0);
    tbl[2] = mkv(1, 0, 0, 32'd0, 0, 0, 32'd0, 1, 0,   0, 44'd0, 0, 0, 0);
    tbl[3] = mkv(0, 1, 4, 32'd99, 0, 0, 32'd0, 1, 0,  0, 44'd0, 0, 0, 0);
    tbl[4] = mkv(1, 0, 0, 32'd0, 1, 5, 32'h55, 0, 0,  1, rec(2, 5, 32'h55), 1, 0, 0);
    tbl[5] = mkv(1, 1, 6, 32'd1, 1, 6, 32'd2, 0, 0,   1, rec(2, 5, 32'h55), 3, 0, 0);
    tbl[6] = mkv(1, 0, 0, 32'd0, 0, 0, 32'd0, 1, 0,   1, rec(3, 6, 32'd1), 2, 0, 0);
    tbl[7] = mkv(1, 1, 7, 32'hdeadbeef, 0, 0, 32'd0, 1, 0, 1, rec(4, 6, 32'd2), 2, 0, 0);
    tbl[8] = mkv(1, 0, 0, 32'd0, 0, 0, 32'd0, 1, 0,   1, rec(5, 7, 32'hdeadbeef), 1, 0, 0);
    tbl[9] = mkv(0, 1, 8, 32'd8, 1, 9, 32'd9, 1, 0,   0, 44'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].en, tbl[i].we1, int'(tbl[i].wa1), tbl[i].wd1, tbl[i].we2, int'(tbl[i].wa2),
            tbl[i].wd2, tbl[i].rdy, tbl[i].clr);
      step();
      $display("vec %0d: valid=%0d data=0x%0h level=%0d", i, trace_valid, trace_data, fifo_level);
      chk($sformatf("v%0d_valid", i), 64'(trace_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("v%0d_data", i),  64'(trace_data),  64'(tbl[i].exp_data));
      chk($sformatf("v%0d_level", i), 64'(fifo_level),  64'(tbl[i].exp_level));
      chk($sformatf("v%0d_drop", i),  64'(drop_cnt),    64'(tbl[i].exp_drop));
      chk($sformatf("v%0d_ovf", i),   64'(ovf_sticky),  64'(tbl[i].exp_ovf));
    end

    // Backpressure: fill, overflow by one, then drain in order.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, i, 32'(100 + i), 0, 0, 32'd0, 0, 0);
      step();
      $display("fill %0d: level=%0d head=0x%0h", i, fifo_level, trace_data);
      chk($sformatf("bp_level%0d", i), 64'(fifo_level), 64'(i + 1));
      chk($sformatf("bp_hold%0d", i),  64'(trace_data), 64'(rec(0, 0, 32'd100)));
    end
    drive(1, 1, 9, 32'd999, 0, 0, 32'd0, 0, 0);
    step();
    $display("overflow: level=%0d drop=%0d ovf=%0d", fifo_level, drop_cnt, ovf_sticky);
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_drop",  64'(drop_cnt),   64'd1);
    chk("ovf_flag",  64'(ovf_sticky), 64'd1);
    chk("ovf_hold",  64'(trace_data), 64'(rec(0, 0, 32'd100)));
    for (int i = 0; i < 8; i++) begin
      $display("drain %0d: valid=%0d data=0x%0h", i, trace_valid, trace_data);
      chk($sformatf("dr_valid%0d", i), 64'(trace_valid), 64'd1);
      chk($sformatf("dr_data%0d", i),  64'(trace_data),  64'(rec(i, i, 32'(100 + i))));
      idle(1'b1);
      step();
    end
    chk("dr_empty", 64'(fifo_level), 64'd0);
    chk("dr_nodata", 64'(trace_data), 64'd0);

    // Full FIFO with pop and dual push: only port 1 fits.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, i, 32'(200 + i), 0, 0, 32'd0, 0, 0);
      step();
    end
    chk("full_level", 64'(fifo_level), 64'd8);
    drive(1, 1, 1, 32'hA1, 1, 2, 32'hA2, 1, 0);
    step();
    $display("full+pop+dual: level=%0d drop=%0d head=0x%0h", fifo_level, drop_cnt, trace_data);
    chk("fpd_level", 64'(fifo_level), 64'd8);
    chk("fpd_drop",  64'(drop_cnt),   64'd2);
    chk("fpd_head",  64'(trace_data), 64'(rec(9, 1, 32'd201)));
    drive(1, 1, 3, 32'hB3, 0, 0, 32'd0, 0, 1);
    step();
    $display("clr+drop: drop=%0d ovf=%0d", drop_cnt, ovf_sticky);
    chk("clrd_drop", 64'(drop_cnt),   64'd1);
    chk("clrd_ovf",  64'(ovf_sticky), 64'd1);
    chk("clrd_level", 64'(fifo_level), 64'd8);
    drive(1, 0, 0, 32'd0, 0, 0, 32'd0, 0, 1);
    step();
    $display("clr: drop=%0d ovf=%0d", drop_cnt, ovf_sticky);
    chk("clr_drop", 64'(drop_cnt),   64'd0);
    chk("clr_ovf",  64'(ovf_sticky), 64'd0);
    for (int j = 0; j < 8; j++) begin
      e = (j < 7) ? rec(9 + j, 1 + j, 32'(201 + j)) : rec(16, 1, 32'hA1);
      $display("drain2 %0d: data=0x%0h", j, trace_data);
      chk($sformatf("dr2_data%0d", j), 64'(trace_data), 64'(e));
      idle(1'b1);
      step();
    end
    chk("dr2_empty", 64'(fifo_level), 64'd0);

    // Sequence and pointer wrap under streaming.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, i % 16, 32'(i), 0, 0, 32'd0, 1, 0);
      step();
      if (i % 50 == 0 || (i >= 254 && i <= 257))
        $display("wrap %0d: data=0x%0h level=%0d", i, trace_data, fifo_level);
      chk($sformatf("wrap_data%0d", i),  64'(trace_data), 64'(rec(i % 256, i % 16, 32'(i))));
      chk($sformatf("wrap_level%0d", i), 64'(fifo_level), 64'd1);
    end
    idle(1'b1);
    step();
    chk("wrap_empty", 64'(fifo_level), 64'd0);
    chk("wrap_drop",  64'(drop_cnt),   64'd0);

    // Asynchronous reset in the middle of a drain.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, i, 32'(300 + i), 0, 0, 32'd0, 0, 0);
      step();
    end
    chk("md_level5", 64'(fifo_level), 64'd5);
    idle(1'b1);
    step();
    chk("md_level4", 64'(fifo_level), 64'd4);
    #2 reset = 1'b0;
    #1;
    $display("mid-drain reset: valid=%0d level=%0d", trace_valid, fifo_level);
    chk("md_valid", 64'(trace_valid), 64'd0);
    chk("md_level", 64'(fifo_level),  64'd0);
    chk("md_data",  64'(trace_data),  64'd0);
    step();
    reset = 1'b1;
    drive(1, 1, 12, 32'h77, 0, 0, 32'd0, 0, 0);
    step();
    $display("post-reset: data=0x%0h", trace_data);
    chk("md_seq0", 64'(trace_data), 64'(rec(0, 12, 32'h77)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
